vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 2 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants shared by the VGA timing generator.
// Sync positions are derived here so every consumer agrees on them.
package vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;   // 800

    // Vertical timing, in lines
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;   // 525

    // Derived sync windows (inclusive bounds)
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;                // 656
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;       // 751
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;                // 490
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;       // 491

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 pixel/line counters with registered decode of
// blank, hs, vs, line_start and frame_start. Decode is computed from the
// next-state counter values so every registered output describes the same
// (DrawX, DrawY) pair that is presented in that cycle.
// Optional build macro VGA_SYNC_DELAY_EN: adds one register stage to hs/vs
// so they line up with a one-cycle registered pixel path.
// Timing defaults come from vga_pkg; the parameters allow a shortened raster.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE_P = H_VISIBLE,
    parameter int unsigned H_FP_P      = H_FP,
    parameter int unsigned H_SYNC_P    = H_SYNC,
    parameter int unsigned H_BP_P      = H_BP,
    parameter int unsigned V_VISIBLE_P = V_VISIBLE,
    parameter int unsigned V_FP_P      = V_FP,
    parameter int unsigned V_SYNC_P    = V_SYNC,
    parameter int unsigned V_BP_P      = V_BP
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start
);

    // 10-bit compare constants derived from the active timing parameters
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE_P + H_FP_P + H_SYNC_P + H_BP_P - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE_P + V_FP_P + V_SYNC_P + V_BP_P - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE_P);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE_P);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE_P + H_FP_P);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE_P + H_FP_P + H_SYNC_P - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE_P + V_FP_P);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE_P + V_FP_P + V_SYNC_P - 1);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       blank_q, blank_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    // Next counter position with explicit wrap, and decode of that position
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = 10'd0;
            if (y_q == V_LAST) begin
                y_d = 10'd0;
            end else begin
                y_d = y_q + 10'd1;
            end
        end else begin
            x_d = x_q + 10'd1;
        end
        blank_d       = (x_d < H_VIS) && (y_d < V_VIS);
        hs_d          = !((x_d >= HS_START) && (x_d <= HS_END));
        vs_d          = !((y_d >= VS_START) && (y_d <= VS_END));
        line_start_d  = (x_d == 10'd0);
        frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
    end

    // Counter and decoded-output registers; reset parks at (0,0) with no pulses
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            blank_q       <= 1'b1;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            blank_q       <= blank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hs_dly_q, hs_dly_d;
    logic vs_dly_q, vs_dly_d;

    // Extra sync stage input: previous cycle's decoded sync
    always_comb begin
        hs_dly_d = hs_q;
        vs_dly_d = vs_q;
    end

    // Extra sync stage; idles at the inactive (high) level
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_dly_q <= 1'b1;
            vs_dly_q <= 1'b1;
        end else begin
            hs_dly_q <= hs_dly_d;
            vs_dly_q <= vs_dly_d;
        end
    end

    assign hs = hs_dly_q;
    assign vs = vs_dly_q;
`else
    assign hs = hs_q;
    assign vs = vs_q;
`endif

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign blank       = blank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
